// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: port indices, flit-type codes and the
// allocator FSM state type.
package noc_pkg;

    localparam int unsigned NPORT = 5;

    localparam int unsigned P_L = 0;
    localparam int unsigned P_E = 1;
    localparam int unsigned P_W = 2;
    localparam int unsigned P_S = 3;
    localparam int unsigned P_N = 4;

    typedef logic [1:0] flit_t;

    localparam flit_t FT_HDR    = 2'b10;
    localparam flit_t FT_BODY   = 2'b00;
    localparam flit_t FT_TAIL   = 2'b01;
    localparam flit_t FT_SINGLE = 2'b11;

    typedef enum logic {StIdle, StLocked} alloc_state_e;

    function automatic logic [2:0] onehot_to_idx(input logic [4:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] wrap_inc(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd0 : v + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arb5.sv
// 5-way arbiter: round-robin from ptr, or fixed priority (index 0 highest) when
// SWALLOC_FIXED_PRIO_EN is defined.
module rr_arb5
    import noc_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] gnt
);

`ifdef SWALLOC_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        gnt = 5'b0;
        for (int i = 4; i >= 0; i--) begin
            if (req[i]) gnt = 5'b1 << i;
        end
    end
`else
    logic [2:0] idx;
    logic       found;

    always_comb begin
        gnt   = 5'b0;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 5; k++) begin
            idx = 3'((int'(ptr) + k) % 5);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/noc_switch_alloc.sv
// Switch allocator for the 5-port mesh router: per-output arbitration with a
// wormhole lock held until tail. SWALLOC_FIXED_PRIO_EN selects fixed priority.
module noc_switch_alloc #(
    parameter int unsigned NPORT = noc_pkg::NPORT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       req_vld,
    input  logic [NPORT*NPORT-1:0] req_dir,
    input  logic [2*NPORT-1:0]     flit_type,
    input  logic [NPORT-1:0]       out_rdy,
    output logic [NPORT*NPORT-1:0] out_sel,
    output logic [NPORT-1:0]       out_vld,
    output logic [NPORT-1:0]       in_pop,
    output logic                   err
);
    import noc_pkg::*;

    alloc_state_e     state_q [NPORT];
    logic [2:0]       owner_q [NPORT];
    logic [NPORT-1:0] started_q;
    logic [2:0]       ptr     [NPORT];
    logic             err_q;

    flit_t            ft      [NPORT];
    logic [NPORT-1:0] dir     [NPORT];
    logic [NPORT-1:0] cand    [NPORT];
    logic [NPORT-1:0] gnt     [NPORT];
    logic [NPORT-1:0] owns;
    logic [NPORT-1:0] hdr_ok;
    logic [NPORT-1:0] xfer;
    logic [NPORT-1:0] rel;
    logic             err_now;

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            ft[p]  = flit_type[2*p +: 2];
            dir[p] = req_dir[NPORT*p +: NPORT];
        end
    end

    always_comb begin
        owns    = '0;
        hdr_ok  = '0;
        xfer    = '0;
        rel     = '0;
        out_vld = '0;
        in_pop  = '0;
        err_now = 1'b0;
        for (int o = 0; o < NPORT; o++) begin
            cand[o] = '0;
        end

        for (int o = 0; o < NPORT; o++) begin
            if (state_q[o] == StLocked) owns[owner_q[o]] = 1'b1;
        end

        // Transfers depend only on the registered lock, never on req_dir.
        for (int o = 0; o < NPORT; o++) begin
            if (state_q[o] == StLocked) begin
                xfer[o]    = req_vld[owner_q[o]] && out_rdy[o] && !rst;
                rel[o]     = xfer[o] && ft[owner_q[o]][0];
                out_vld[o] = xfer[o];
                if (xfer[o]) in_pop[owner_q[o]] = 1'b1;
                if (started_q[o] && req_vld[owner_q[o]] && ft[owner_q[o]] == FT_HDR) begin
                    err_now = 1'b1;
                end
            end
        end

        for (int p = 0; p < NPORT; p++) begin
            if (req_vld[p] && !owns[p]) begin
                if (ft[p][1]) begin
                    if ($onehot(dir[p])) hdr_ok[p] = 1'b1;
                    else                 err_now   = 1'b1;
                end else begin
                    err_now = 1'b1;
                end
            end
        end

        for (int o = 0; o < NPORT; o++) begin
            for (int p = 0; p < NPORT; p++) begin
                cand[o][p] = hdr_ok[p] && dir[p][o];
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        rr_arb5 u_arb (
            .req (cand[o]),
            .ptr (ptr[o]),
            .gnt (gnt[o])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NPORT; o++) begin
                state_q[o] <= StIdle;
                owner_q[o] <= 3'd0;
            end
            started_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= err_q | err_now;
            for (int o = 0; o < NPORT; o++) begin
                unique case (state_q[o])
                    StIdle: begin
                        if (|gnt[o]) begin
                            state_q[o]   <= StLocked;
                            owner_q[o]   <= onehot_to_idx(gnt[o]);
                            started_q[o] <= 1'b0;
                        end
                    end
                    StLocked: begin
                        if (xfer[o]) begin
                            started_q[o] <= 1'b1;
                            if (rel[o]) state_q[o] <= StIdle;
                        end
                    end
                    default: state_q[o] <= StIdle;
                endcase
            end
        end
    end

`ifdef SWALLOC_FIXED_PRIO_EN
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            ptr[o] = 3'd0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NPORT; o++) begin
                ptr[o] <= 3'd0;
            end
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (rel[o]) ptr[o] <= wrap_inc(owner_q[o]);
            end
        end
    end
`endif

    always_comb begin
        out_sel = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int p = 0; p < NPORT; p++) begin
                out_sel[NPORT*o + p] = (state_q[o] == StLocked) && (owner_q[o] == 3'(p));
            end
        end
    end

    assign err = err_q;

endmodule
